// File: rtl/qnigma_poly1305_alu.sv
// qnigma_poly1305_alu
// Responder for the Poly1305 ALU handshake. On an accepted alu_cal it reads
// operand A (ptr_opa) and operand B (ptr_opb) from the operand RAM, then
// computes (A+B) mod p or (A*B) mod p with p = 2^FIELD_BITS-5. The fully
// reduced result is returned on alu_res and held while alu_rdy is high.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   alu_cal             request, sampled only while alu_rdy=1
//   alu_add / alu_mul   one-hot opcode; both or neither -> alu_err pulse
//   ptr_opa / ptr_opb   operand RAM addresses
//   ram_rd / ram_addr   operand RAM read strobe and address
//   ram_dat             read data, valid RAM_LAT cycles after ram_rd
//   alu_res             result (< p), changes only at completion or reset
//   alu_rdy             idle / result valid
//   alu_err             one-cycle pulse on an illegal opcode
//
// Build option POLY1305_ALU_WB_EN: adds ram_we / ram_wdat and a write-back
// state after FIN that stores the result to ptr_opa; alu_rdy rises one cycle
// later than without the option.
module qnigma_poly1305_alu #(
    parameter int FIELD_BITS = 130,
    parameter int DIGIT_BITS = 2,
    parameter int PTR_BITS   = 4,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_cal,
    input  logic                  alu_add,
    input  logic                  alu_mul,
    input  logic [PTR_BITS-1:0]   ptr_opa,
    input  logic [PTR_BITS-1:0]   ptr_opb,
    output logic                  ram_rd,
    output logic [PTR_BITS-1:0]   ram_addr,
    input  logic [FIELD_BITS-1:0] ram_dat,
`ifdef POLY1305_ALU_WB_EN
    output logic                  ram_we,
    output logic [FIELD_BITS-1:0] ram_wdat,
`endif
    output logic [FIELD_BITS-1:0] alu_res,
    output logic                  alu_rdy,
    output logic                  alu_err
);

    localparam int NDIG = FIELD_BITS / DIGIT_BITS;
    localparam int AW   = FIELD_BITS + 1;              // accumulator width
    localparam int MW   = FIELD_BITS + DIGIT_BITS + 2; // Horner step width
    localparam int WCW  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam int DCW  = $clog2(NDIG + 1);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] P   = (ONE << FIELD_BITS) - AW'(5);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RDA  = 4'd1;
    localparam logic [3:0] S_WTA  = 4'd2;
    localparam logic [3:0] S_RDB  = 4'd3;
    localparam logic [3:0] S_WTB  = 4'd4;
    localparam logic [3:0] S_ADD  = 4'd5;
    localparam logic [3:0] S_MUL  = 4'd6;
    localparam logic [3:0] S_FIN  = 4'd7;
`ifdef POLY1305_ALU_WB_EN
    localparam logic [3:0] S_WB   = 4'd8;
`endif

    logic [3:0]            state;
    logic                  is_mul;
    logic [PTR_BITS-1:0]   pa, pb;
    logic [WCW-1:0]        wcnt;
    logic [DCW-1:0]        dcnt;
    logic [FIELD_BITS-1:0] a_reg, b_reg;
    logic [AW-1:0]         acc;

    // ADD: 2^FIELD_BITS == 5 (mod p), so the carry folds back in as 5.
    logic [AW-1:0] add_sum, add_fold;
    assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    assign add_fold = {1'b0, add_sum[FIELD_BITS-1:0]}
                    + {{(AW-3){1'b0}}, add_sum[FIELD_BITS], 1'b0, add_sum[FIELD_BITS]};

    // MUL: one Horner step on the top digit of the (shifting) B register.
    // Overflow above FIELD_BITS is folded as 5*high = 4*high + high, which
    // keeps acc below 2^FIELD_BITS plus a small slack.
    logic [DIGIT_BITS-1:0] digit;
    logic [MW-1:0]         mul_sum;
    logic [DIGIT_BITS+1:0] mul_hi;
    logic [AW-1:0]         mul_fold;
    assign digit    = b_reg[FIELD_BITS-1 -: DIGIT_BITS];
    assign mul_sum  = {1'b0, acc, {DIGIT_BITS{1'b0}}} + MW'(a_reg) * MW'(digit);
    assign mul_hi   = mul_sum[MW-1:FIELD_BITS];
    assign mul_fold = {1'b0, mul_sum[FIELD_BITS-1:0]} + AW'(mul_hi) + AW'({mul_hi, 2'b00});

    // acc < 2p in both paths, so a single conditional subtract fully reduces.
    logic [FIELD_BITS-1:0] red;
    assign red = (acc >= P) ? FIELD_BITS'(acc - P) : acc[FIELD_BITS-1:0];

    assign ram_rd   = (state == S_RDA) || (state == S_RDB);
    assign ram_addr = ((state == S_RDB) || (state == S_WTB)) ? pb : pa;
    assign alu_rdy  = (state == S_IDLE);
`ifdef POLY1305_ALU_WB_EN
    assign ram_we   = (state == S_WB);
    assign ram_wdat = alu_res;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            is_mul  <= 1'b0;
            pa      <= '0;
            pb      <= '0;
            wcnt    <= '0;
            dcnt    <= '0;
            acc     <= '0;
            alu_res <= '0;
            alu_err <= 1'b0;
        end else begin
            alu_err <= 1'b0;
            case (state)
                S_IDLE: if (alu_cal) begin
                    if (alu_add ^ alu_mul) begin
                        is_mul <= alu_mul;
                        pa     <= ptr_opa;
                        pb     <= ptr_opb;
                        state  <= S_RDA;
                    end else begin
                        alu_err <= 1'b1;
                    end
                end
                S_RDA: begin
                    wcnt  <= '0;
                    state <= S_WTA;
                end
                S_WTA: if (wcnt == WCW'(RAM_LAT - 1)) begin
                    a_reg <= ram_dat;
                    state <= S_RDB;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                S_RDB: begin
                    wcnt  <= '0;
                    state <= S_WTB;
                end
                S_WTB: if (wcnt == WCW'(RAM_LAT - 1)) begin
                    b_reg <= ram_dat;
                    acc   <= '0;
                    dcnt  <= '0;
                    state <= is_mul ? S_MUL : S_ADD;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                S_ADD: begin
                    acc   <= add_fold;
                    state <= S_FIN;
                end
                S_MUL: begin
                    acc   <= mul_fold;
                    b_reg <= b_reg << DIGIT_BITS;
                    dcnt  <= dcnt + 1'b1;
                    if (dcnt == DCW'(NDIG - 1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    alu_res <= red;
`ifdef POLY1305_ALU_WB_EN
                    state   <= S_WB;
`else
                    state   <= S_IDLE;
`endif
                end
`ifdef POLY1305_ALU_WB_EN
                S_WB:    state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qnigma_poly1305_alu.sv
// Self-checking bench for qnigma_poly1305_alu: directed corner cases plus
// randomized operations checked against a big-integer modular model.
module tb_qnigma_poly1305_alu;

    localparam int FB   = 130;
    localparam int DB   = 2;
    localparam int PB   = 4;
    localparam int LAT  = 1;
    localparam int NDIG = FB / DB;
`ifdef POLY1305_ALU_WB_EN
    localparam int WBX = 1;
`else
    localparam int WBX = 0;
`endif
    localparam int ADD_LAT = 4 + 2 * LAT + WBX;
    localparam int MUL_LAT = 3 + 2 * LAT + NDIG + WBX;
    localparam logic [FB:0] ONE = (FB+1)'(1);
    localparam logic [FB:0] PW  = (ONE << FB) - (FB+1)'(5);

    logic clk = 1'b0;
    logic rst;
    logic alu_cal, alu_add, alu_mul;
    logic [PB-1:0] ptr_opa, ptr_opb;
    logic ram_rd;
    logic [PB-1:0] ram_addr;
    logic [FB-1:0] ram_dat;
    logic [FB-1:0] alu_res;
    logic alu_rdy, alu_err;
`ifdef POLY1305_ALU_WB_EN
    logic ram_we;
    logic [FB-1:0] ram_wdat;
    logic [PB-1:0] we_a_q[$];
    logic [FB-1:0] we_d_q[$];
`endif

    logic [FB-1:0] mem [16];
    logic [PB-1:0] rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int glitches = 0;
    logic mon_en = 1'b0;
    logic prev_rdy = 1'b0;
    logic [FB-1:0] prev_res = '0;

    qnigma_poly1305_alu #(
        .FIELD_BITS(FB), .DIGIT_BITS(DB), .PTR_BITS(PB), .RAM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_cal(alu_cal), .alu_add(alu_add), .alu_mul(alu_mul),
        .ptr_opa(ptr_opa), .ptr_opb(ptr_opb),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_dat(ram_dat),
`ifdef POLY1305_ALU_WB_EN
        .ram_we(ram_we), .ram_wdat(ram_wdat),
`endif
        .alu_res(alu_res), .alu_rdy(alu_rdy), .alu_err(alu_err)
    );

    always #5 clk = ~clk;

    // operand RAM, one-cycle read latency
    always @(posedge clk) if (ram_rd) ram_dat <= mem[ram_addr];

    always @(negedge clk) begin
        if (ram_rd) rd_q.push_back(ram_addr);
`ifdef POLY1305_ALU_WB_EN
        if (ram_we) begin
            we_a_q.push_back(ram_addr);
            we_d_q.push_back(ram_wdat);
        end
`endif
        if (mon_en && alu_rdy && prev_rdy && alu_res !== prev_res) glitches <= glitches + 1;
        prev_rdy <= alu_rdy;
        prev_res <= alu_res;
    end

    // reference model: plain modular arithmetic on wide integers
    function automatic logic [FB-1:0] m_add(input logic [FB-1:0] a, input logic [FB-1:0] b);
        logic [FB+1:0] s  = {2'b00, a} + {2'b00, b};
        logic [FB+1:0] pp = {1'b0, PW};
        return FB'(s % pp);
    endfunction

    function automatic logic [FB-1:0] m_mul(input logic [FB-1:0] a, input logic [FB-1:0] b);
        logic [2*FB-1:0] pr = {{FB{1'b0}}, a} * {{FB{1'b0}}, b};
        logic [2*FB-1:0] pp = {{(FB-1){1'b0}}, PW};
        return FB'(pr % pp);
    endfunction

    function automatic logic [FB-1:0] rnd_op();
        logic [159:0] v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        logic [FB-1:0] r;
        case ($urandom_range(0, 3))
            0:       r = v[FB-1:0];
            1:       r = PW[FB-1:0] - FB'(v[2:0]) + FB'(3);
            2:       r = {FB{1'b1}} - FB'(v[3:0]);
            default: r = FB'(v[7:0]);
        endcase
        return r;
    endfunction

    // Issue one request and wait for completion; cal is held for 'hold'
    // extra cycles after acceptance. lat = edges from accept to alu_rdy.
    task automatic run_op(input logic add, input logic mul, input logic [PB-1:0] pa,
                          input logic [PB-1:0] pb, input int hold,
                          output logic [FB-1:0] res, output int lat);
        @(negedge clk);
        alu_cal = 1'b1; alu_add = add; alu_mul = mul; ptr_opa = pa; ptr_opb = pb;
        @(posedge clk);
        #1;
        if (hold == 0) alu_cal = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat >= hold) alu_cal = 1'b0;
        end while (!alu_rdy && lat < 300);
        alu_cal = 1'b0;
        res = alu_res;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (alu_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", alu_rdy); end
        n_cmp++; if (alu_res !== '0) begin n_bad++; $display("FAIL reset_res: got %0h want 0", alu_res); end
        n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ram_rd: got %b want 0", ram_rd); end
        n_cmp++; if (alu_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", alu_err); end
        n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", ram_addr); end
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_add();
        logic [FB-1:0] res;
        int lat, base;
        logic [7:0] seq;
        mem[3] = PW[FB-1:0] - FB'(1);
        mem[7] = FB'(2);
        base = rd_q.size();
        run_op(1'b1, 1'b0, 4'd3, 4'd7, 0, res, lat);
        n_cmp++; if (res !== FB'(1)) begin n_bad++; $display("FAIL add_pm1_2: got %0h want 1", res); end
        n_cmp++; if (lat != ADD_LAT) begin n_bad++; $display("FAIL add_latency: got %0d want %0d", lat, ADD_LAT); end
        seq = (rd_q.size() == base + 2) ? {rd_q[base], rd_q[base+1]} : 8'hff;
        n_cmp++; if (seq !== 8'h37) begin n_bad++; $display("FAIL add_read_seq: got %0h want 37", seq); end
        mem[1] = {FB{1'b1}};
        mem[2] = {FB{1'b1}};
        run_op(1'b1, 1'b0, 4'd1, 4'd2, 0, res, lat);
        n_cmp++; if (res !== FB'(8)) begin n_bad++; $display("FAIL add_unreduced: got %0h want 8", res); end
        base = rd_q.size();
        run_op(1'b1, 1'b0, 4'd1, 4'd1, 0, res, lat);
        n_cmp++; if (res !== FB'(8)) begin n_bad++; $display("FAIL add_same_ptr: got %0h want 8", res); end
        seq = (rd_q.size() == base + 2) ? {rd_q[base], rd_q[base+1]} : 8'hff;
        n_cmp++; if (seq !== 8'h11) begin n_bad++; $display("FAIL add_same_ptr_seq: got %0h want 11", seq); end
    endtask

    task automatic test_mul();
        logic [FB-1:0] res;
        int lat;
        mem[4] = FB'(1) << 128;
        mem[5] = FB'(4);
        run_op(1'b0, 1'b1, 4'd4, 4'd5, 0, res, lat);
        n_cmp++; if (res !== FB'(5)) begin n_bad++; $display("FAIL mul_2p128_x4: got %0h want 5", res); end
        n_cmp++; if (lat != MUL_LAT) begin n_bad++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
        mem[6] = PW[FB-1:0] - FB'(1);
        run_op(1'b0, 1'b1, 4'd6, 4'd6, 0, res, lat);
        n_cmp++; if (res !== FB'(1)) begin n_bad++; $display("FAIL mul_pm1_sq: got %0h want 1", res); end
        mem[8] = FB'(16'h1234);
        mem[9] = '0;
        run_op(1'b0, 1'b1, 4'd8, 4'd9, 0, res, lat);
        n_cmp++; if (res !== '0) begin n_bad++; $display("FAIL mul_by_zero: got %0h want 0", res); end
    endtask

    task automatic test_err();
        logic [FB-1:0] held;
        int base;
        held = alu_res;
        base = rd_q.size();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            alu_cal = 1'b1; alu_add = (k == 0); alu_mul = (k == 0);
            @(posedge clk);
            #1;
            alu_cal = 1'b0;
            n_cmp++; if (alu_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse_%0d: got %b want 1", k, alu_err); end
            n_cmp++; if (alu_rdy !== 1'b1) begin n_bad++; $display("FAIL err_rdy_%0d: got %b want 1", k, alu_rdy); end
            @(posedge clk);
            #1;
            n_cmp++; if (alu_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle_%0d: got %b want 0", k, alu_err); end
        end
        n_cmp++; if (alu_res !== held) begin n_bad++; $display("FAIL err_res_held: got %0h want %0h", alu_res, held); end
        n_cmp++; if (rd_q.size() != base) begin n_bad++; $display("FAIL err_no_reads: got %0d want %0d", rd_q.size(), base); end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] res, a, b;
        int lat, base, busy;
        a = rnd_op(); b = rnd_op();
        mem[10] = a; mem[11] = b;
        base = rd_q.size();
        run_op(1'b0, 1'b1, 4'd10, 4'd11, 3, res, lat);
        n_cmp++; if (res !== m_mul(a, b)) begin n_bad++; $display("FAIL busy_cal_res: got %0h want %0h", res, m_mul(a, b)); end
        n_cmp++; if (lat != MUL_LAT) begin n_bad++; $display("FAIL busy_cal_lat: got %0d want %0d", lat, MUL_LAT); end
        busy = 0;
        repeat (10) begin @(posedge clk); #1; if (!alu_rdy) busy++; end
        n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL busy_cal_one_op: got %0d busy cycles want 0", busy); end
        n_cmp++; if (rd_q.size() != base + 2) begin n_bad++; $display("FAIL busy_cal_reads: got %0d want %0d", rd_q.size() - base, 2); end
    endtask

    task automatic test_ram_change();
        logic [FB-1:0] res, a, b;
        int lat;
        a = rnd_op(); b = rnd_op();
        mem[12] = a; mem[13] = b;
        fork
            run_op(1'b0, 1'b1, 4'd12, 4'd13, 0, res, lat);
            begin repeat (7) @(posedge clk); mem[12] = ~a; mem[13] = ~b; end
        join
        n_cmp++; if (res !== m_mul(a, b)) begin n_bad++; $display("FAIL ram_change: got %0h want %0h", res, m_mul(a, b)); end
    endtask

    task automatic test_random();
        logic [FB-1:0] res, a, b, exp;
        logic [PB-1:0] pa, pb;
        logic is_mul;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = rnd_op(); b = rnd_op();
            pa = PB'($urandom_range(0, 15));
            pb = PB'($urandom_range(0, 15));
            if (pa == pb) b = a;
            mem[pa] = a; mem[pb] = b;
            is_mul = 1'($urandom_range(0, 1));
            exp = is_mul ? m_mul(a, b) : m_add(a, b);
            run_op(!is_mul, is_mul, pa, pb, 0, res, lat);
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rand_%0d_%s: got %0h want %0h", i, is_mul ? "mul" : "add", res, exp); end
            n_cmp++; if (lat != (is_mul ? MUL_LAT : ADD_LAT)) begin n_bad++; $display("FAIL rand_%0d_lat: got %0d want %0d", i, lat, is_mul ? MUL_LAT : ADD_LAT); end
        end
    endtask

    task automatic test_reset_mid();
        logic [FB-1:0] res;
        int lat;
        mem[4] = rnd_op(); mem[5] = rnd_op();
        mon_en = 1'b0;
        @(negedge clk);
        alu_cal = 1'b1; alu_add = 1'b0; alu_mul = 1'b1; ptr_opa = 4'd4; ptr_opb = 4'd5;
        @(posedge clk);
        #1;
        alu_cal = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (alu_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_rdy: got %b want 1", alu_rdy); end
        n_cmp++; if (alu_res !== '0) begin n_bad++; $display("FAIL midrst_res: got %0h want 0", alu_res); end
        n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL midrst_ram_rd: got %b want 0", ram_rd); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        mem[0] = FB'(3); mem[1] = FB'(4);
        run_op(1'b1, 1'b0, 4'd0, 4'd1, 0, res, lat);
        n_cmp++; if (res !== FB'(7)) begin n_bad++; $display("FAIL midrst_add: got %0h want 7", res); end
        n_cmp++; if (lat != ADD_LAT) begin n_bad++; $display("FAIL midrst_add_lat: got %0d want %0d", lat, ADD_LAT); end
    endtask

`ifdef POLY1305_ALU_WB_EN
    task automatic test_wb();
        logic [FB-1:0] res;
        int lat, wbase;
        mem[2] = FB'(10); mem[3] = FB'(20);
        wbase = we_a_q.size();
        run_op(1'b1, 1'b0, 4'd2, 4'd3, 0, res, lat);
        n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL wb_lat: got %0d want 7", lat); end
        n_cmp++; if (we_a_q.size() != wbase + 1) begin n_bad++; $display("FAIL wb_count: got %0d want 1", we_a_q.size() - wbase); end
        else begin
            n_cmp++; if (we_a_q[wbase] !== 4'd2) begin n_bad++; $display("FAIL wb_addr: got %0h want 2", we_a_q[wbase]); end
            n_cmp++; if (we_d_q[wbase] !== FB'(30)) begin n_bad++; $display("FAIL wb_data: got %0h want 1e", we_d_q[wbase]); end
        end
        n_cmp++; if (res !== FB'(30)) begin n_bad++; $display("FAIL wb_res: got %0h want 1e", res); end
    endtask
`endif

    initial begin
        rst = 1'b0; alu_cal = 1'b0; alu_add = 1'b0; alu_mul = 1'b0;
        ptr_opa = '0; ptr_opb = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_add();
        test_mul();
        test_err();
        test_back_to_back();
        test_ram_change();
        test_random();
        test_reset_mid();
`ifdef POLY1305_ALU_WB_EN
        test_wb();
`endif
        n_cmp++; if (glitches != 0) begin n_bad++; $display("FAIL res_stable: got %0d changes while ready want 0", glitches); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
